pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_if.sv | 40 ++++
 rtl/pipeline_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Pipeline control bundle between the datapath stages and the hazard controller.
// The master side is the pipeline datapath and the slave side is pipeline_ctrl.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 16
);
  // Register addresses seen by the Decode, Execute, Memory and Writeback stages
  logic [4:0]       rs1D, rs2D;
  logic [4:0]       rs1E, rs2E;
  logic [4:0]       rdE, rdM, rdW;
  logic             load_E;
  logic             reg_write_M, reg_write_W;
  logic             pc_src_E;
  logic             dmem_req, dmem_ready;

  // Controls returned to the stage registers and the operand muxes
  logic             stall_F, stall_D, stall_E, stall_M;
  logic             flush_D, flush_E, flush_W;
  logic [1:0]       fwd_A_E, fwd_B_E;

  // Status
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [1:0]       state;

  modport master (
    output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
    output load_E, reg_write_M, reg_write_W, pc_src_E, dmem_req, dmem_ready,
    input  stall_F, stall_D, stall_E, stall_M,
    input  flush_D, flush_E, flush_W, fwd_A_E, fwd_B_E,
    input  mem_timeout, stall_cycles, state
  );

  modport slave (
    input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
    input  load_E, reg_write_M, reg_write_W, pc_src_E, dmem_req, dmem_ready,
    output stall_F, stall_D, stall_E, stall_M,
    output flush_D, flush_E, flush_W, fwd_A_E, fwd_B_E,
    output mem_timeout, stall_cycles, state
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard controller for a five-stage pipeline: operand forwarding, load-use
// stalls, branch flushes and data-memory wait handling with a timeout fault.
// Stall/flush/forward outputs are purely combinational from state and inputs.
module pipeline_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input logic           clk,
  input logic           reset,
  pipeline_ctrl_if.slave bus
);

  // Wait counter is at least 8 bits and always wide enough to hold TIMEOUT
  localparam int WAIT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    FAULT    = 2'b10
  } state_t;

  state_t            state_reg, state_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic              mem_timeout_reg, mem_timeout_next;
  logic [CNT_W-1:0]  stall_cnt_reg;

  logic mem_wait, lw_stall;
  logic stall_f_raw, stall_d_raw, stall_e_raw, stall_m_raw;
  logic flush_d_raw, flush_e_raw, flush_w_raw;

  // Memory stage result has priority over Writeback; x0 is never forwarded
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                         input logic [4:0] rd_w, input logic wr_m,
                                         input logic wr_w);
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs))      return 2'b10;
    else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) return 2'b01;
    else                                             return 2'b00;
  endfunction

  assign mem_wait = bus.dmem_req & ~bus.dmem_ready;
  assign lw_stall = bus.load_E & (bus.rdE != 5'd0) &
                    ((bus.rdE == bus.rs1D) | (bus.rdE == bus.rs2D));

  assign bus.fwd_A_E = fwd_sel(bus.rs1E, bus.rdM, bus.rdW, bus.reg_write_M, bus.reg_write_W);
  assign bus.fwd_B_E = fwd_sel(bus.rs2E, bus.rdM, bus.rdW, bus.reg_write_M, bus.reg_write_W);

  // Next-state, wait counter and stall/flush priority: memory hold > branch > load-use
  always_comb begin
    state_next       = state_reg;
    wait_cnt_next    = wait_cnt_reg;
    mem_timeout_next = mem_timeout_reg;
    stall_f_raw      = 1'b0;
    stall_d_raw      = 1'b0;
    stall_e_raw      = 1'b0;
    stall_m_raw      = 1'b0;
    flush_d_raw      = 1'b0;
    flush_e_raw      = 1'b0;
    flush_w_raw      = 1'b0;

    case (state_reg)
      RUN: begin
        if (mem_wait) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!mem_wait) begin
          // completion wins even on the cycle the limit would be reached
          state_next    = RUN;
          wait_cnt_next = '0;
        end else if ((wait_cnt_reg + WAIT_W'(1)) >= TIMEOUT_V) begin
          state_next       = FAULT;
          wait_cnt_next    = '0;
          mem_timeout_next = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
        end
      end
      FAULT: begin
        mem_timeout_next = 1'b1;
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = '0;
      end
    endcase

    if ((state_reg == FAULT) || mem_wait) begin
      // freeze everything; a pending branch stays held in Execute
      stall_f_raw = 1'b1;
      stall_d_raw = 1'b1;
      stall_e_raw = 1'b1;
      stall_m_raw = 1'b1;
      flush_w_raw = 1'b1;
    end else if (bus.pc_src_E) begin
      flush_d_raw = 1'b1;
      flush_e_raw = 1'b1;
    end else if (lw_stall) begin
      stall_f_raw = 1'b1;
      stall_d_raw = 1'b1;
      flush_e_raw = 1'b1;
    end
  end

  // A clear on a held stage register would be lost, so never present both;
  // reset forces all stage controls low without waiting for a clock edge
  assign bus.stall_F = stall_f_raw & reset;
  assign bus.stall_D = stall_d_raw & reset;
  assign bus.stall_E = stall_e_raw & reset;
  assign bus.stall_M = stall_m_raw & reset;
  assign bus.flush_D = flush_d_raw & ~stall_d_raw & reset;
  assign bus.flush_E = flush_e_raw & ~stall_e_raw & reset;
  assign bus.flush_W = flush_w_raw & reset;

  assign bus.state        = state_reg;
  assign bus.mem_timeout  = mem_timeout_reg;
  assign bus.stall_cycles = stall_cnt_reg;

  // FSM state, wait counter and sticky fault flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= RUN;
      wait_cnt_reg    <= '0;
      mem_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      wait_cnt_reg    <= wait_cnt_next;
      mem_timeout_reg <= mem_timeout_next;
    end
  end

  // Saturating count of fetch-stall cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_reg <= '0;
    end else if (stall_f_raw && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed scenarios plus random traffic,
// expectations from a run-length reference model of the hazard rules.
module tb_pipeline_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;
  localparam int SAT     = (1 << CNT_W) - 1;
  localparam int OW      = 14 + CNT_W;

  typedef logic [OW-1:0] obs_t;

  typedef struct {
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       load_E, reg_write_M, reg_write_W, pc_src_E, dmem_req, dmem_ready;
  } stim_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  obs_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  // Reference model: length of the current run of memory-wait cycles,
  // fault flag and stall-cycle total
  int m_wait_len = 0;
  bit m_fault    = 0;
  int m_cnt      = 0;

  function automatic stim_t idle();
    stim_t s;
    s.rs1D = 0; s.rs2D = 0; s.rs1E = 0; s.rs2E = 0;
    s.rdE = 0; s.rdM = 0; s.rdW = 0;
    s.load_E = 0; s.reg_write_M = 0; s.reg_write_W = 0;
    s.pc_src_E = 0; s.dmem_req = 0; s.dmem_ready = 0;
    return s;
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input stim_t s);
    if (rs == 0) return 2'b00;
    if (s.reg_write_M && s.rdM == rs) return 2'b10;
    if (s.reg_write_W && s.rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit ref_lw(input stim_t s);
    return s.load_E && (s.rdE != 0) && (s.rdE == s.rs1D || s.rdE == s.rs2D);
  endfunction

  function automatic obs_t model_out(input stim_t s);
    bit         mw;
    logic [3:0] stl;
    logic [2:0] fl;
    logic [1:0] st;
    mw = s.dmem_req && !s.dmem_ready;
    if (m_fault || mw)    begin stl = 4'b1111; fl = 3'b001; end
    else if (s.pc_src_E)  begin stl = 4'b0000; fl = 3'b110; end
    else if (ref_lw(s))   begin stl = 4'b1100; fl = 3'b010; end
    else                  begin stl = 4'b0000; fl = 3'b000; end
    st = m_fault ? 2'd2 : ((m_wait_len > 0) ? 2'd1 : 2'd0);
    return {stl, fl, ref_fwd(s.rs1E, s), ref_fwd(s.rs2E, s), m_fault, st, CNT_W'(m_cnt)};
  endfunction

  task automatic model_step(input stim_t s);
    bit mw;
    bit stall_f;
    mw = s.dmem_req && !s.dmem_ready;
    stall_f = m_fault || mw || (!s.pc_src_E && ref_lw(s));
    if (stall_f && m_cnt < SAT) m_cnt++;
    if (!m_fault) begin
      if (mw) begin
        m_wait_len++;
        if (m_wait_len >= TIMEOUT) m_fault = 1;
      end else begin
        m_wait_len = 0;
      end
    end
  endtask

  task automatic drive(input stim_t s);
    bus.rs1D = s.rs1D; bus.rs2D = s.rs2D; bus.rs1E = s.rs1E; bus.rs2E = s.rs2E;
    bus.rdE = s.rdE; bus.rdM = s.rdM; bus.rdW = s.rdW;
    bus.load_E = s.load_E; bus.reg_write_M = s.reg_write_M; bus.reg_write_W = s.reg_write_W;
    bus.pc_src_E = s.pc_src_E; bus.dmem_req = s.dmem_req; bus.dmem_ready = s.dmem_ready;
  endtask

  // One pipeline cycle: drive, record the expected response, advance the model
  task automatic apply(input stim_t s);
    @(posedge clk);
    #1;
    drive(s);
    exp_q.push_back(model_out(s));
    model_step(s);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("chk %s ok value=%0h", name, act);
    end
  endtask

  // Mid-cycle reset pulse with hazard-provoking inputs, checked before any edge
  task automatic reset_check();
    stim_t s;
    @(posedge clk);
    #1;
    s = idle();
    s.dmem_req = 1; s.load_E = 1; s.rdE = 7; s.rs1D = 7; s.pc_src_E = 1;
    drive(s);
    #1 reset = 1'b0;
    #1;
    chk("reset state", 32'(bus.state), 32'd0);
    chk("reset mem_timeout", 32'(bus.mem_timeout), 32'd0);
    chk("reset stall_cycles", 32'(bus.stall_cycles), 32'd0);
    chk("reset stall/flush", 32'({bus.stall_F, bus.stall_D, bus.stall_E, bus.stall_M,
                                  bus.flush_D, bus.flush_E, bus.flush_W}), 32'd0);
    drive(idle());
    #1 reset = 1'b1;
    m_fault = 0; m_wait_len = 0; m_cnt = 0;
  endtask

  // Monitor: pop one expectation per presented cycle
  initial begin
    obs_t act, req;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        req = exp_q.pop_front();
        act = {bus.stall_F, bus.stall_D, bus.stall_E, bus.stall_M,
               bus.flush_D, bus.flush_E, bus.flush_W,
               bus.fwd_A_E, bus.fwd_B_E, bus.mem_timeout, bus.state, bus.stall_cycles};
        vectors++;
        if (act !== req) begin
          miscompares++;
          $display("FAIL outputs t=%0t actual=%h required=%h", $time, act, req);
        end else begin
          $display("vec %0d t=%0t outputs=%h ok", vectors, $time, act);
        end
      end
    end
  end

  initial begin
    stim_t s;
    int    fault_age;
    drive(idle());
    reset = 1'b0;
    reset_check();

    // Forwarding: Memory over Writeback, then Writeback when rdM is x0
    s = idle();
    s.rs1E = 5; s.rdM = 5; s.reg_write_M = 1; s.rdW = 5; s.reg_write_W = 1; s.rs2E = 3;
    apply(s);
    s.rdM = 0;
    apply(s);
    s.rs2E = 5; s.rdW = 0;
    apply(s);

    // Load-use, then the same with rdE = x0
    s = idle();
    s.load_E = 1; s.rdE = 7; s.rs2D = 7;
    apply(s);
    apply(idle());
    s.rdE = 0;
    apply(s);

    // Branch over load-use
    s.rdE = 7; s.pc_src_E = 1;
    apply(s);
    apply(idle());

    // Memory wait of three cycles with a held branch
    s = idle();
    s.dmem_req = 1; s.pc_src_E = 1;
    repeat (3) apply(s);
    s.dmem_ready = 1;
    apply(s);
    apply(idle());

    // Completion on the cycle the limit would be reached
    s = idle();
    s.dmem_req = 1;
    repeat (TIMEOUT - 1) apply(s);
    s.dmem_ready = 1;
    apply(s);
    apply(idle());

    // Timeout into FAULT, which persists, then reset mid-fault
    s = idle();
    s.dmem_req = 1;
    repeat (TIMEOUT) apply(s);
    s.dmem_ready = 1;
    repeat (3) apply(s);
    reset_check();
    apply(idle());

    // Stall-counter saturation
    s = idle();
    s.load_E = 1; s.rdE = 9; s.rs1D = 9;
    repeat (20) apply(s);
    apply(idle());
    reset_check();

    // Random traffic with narrow register ranges to provoke hazards
    fault_age = 0;
    for (int i = 0; i < 600; i++) begin
      if ((i % 60) == 59 || fault_age > 4) begin
        reset_check();
        fault_age = 0;
      end else begin
        s.rs1D = 5'($urandom_range(0, 3));
        s.rs2D = 5'($urandom_range(0, 3));
        s.rs1E = 5'($urandom_range(0, 3));
        s.rs2E = 5'($urandom_range(0, 3));
        s.rdE  = 5'($urandom_range(0, 3));
        s.rdM  = 5'($urandom_range(0, 3));
        s.rdW  = 5'($urandom_range(0, 3));
        s.load_E      = ($urandom_range(0, 2) == 0);
        s.reg_write_M = $urandom_range(0, 1);
        s.reg_write_W = $urandom_range(0, 1);
        s.pc_src_E    = ($urandom_range(0, 7) == 0);
        if ((i % 50) < 5) begin
          s.dmem_req = 1; s.dmem_ready = 0;
        end else begin
          s.dmem_req   = $urandom_range(0, 1);
          s.dmem_ready = ($urandom_range(0, 2) == 0);
        end
        apply(s);
        if (m_fault) fault_age++;
      end
    end

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
